// File: rtl/led_strip_pkg.sv
// Shared types and constants for the WS2812-style strip transmitter:
// colour word layout, wire byte order and the frame FSM states.
package led_strip_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  localparam logic [4:0] R_OFS = 5'd16;
  localparam logic [4:0] G_OFS = 5'd8;
  localparam logic [4:0] B_OFS = 5'd0;

  // Bytes go out on the wire as G, R, B, each MSB first.
  localparam logic [4:0] WIRE_OFS [3] = '{G_OFS, R_OFS, B_OFS};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } tx_state_t;

  // Colour bit carried by wire position idx (0..23) of one LED.
  function automatic logic wire_bit(input color_t c, input logic [4:0] idx);
    logic [23:0] v;
    logic [1:0]  slot;
    logic [4:0]  pos;
    v    = c;
    slot = idx[4:3];
    if (slot == 2'd3) slot = 2'd2;
    pos  = WIRE_OFS[slot] + 5'd7 - {2'b00, idx[2:0]};
    return v[pos];
  endfunction

endpackage

// File: rtl/led_strip_tx_if.sv
// Frame/handshake bundle between the colour controllers and the strip
// transmitter: snapshot source, start request, status and the data line.
interface led_strip_tx_if #(
  parameter int NUM_LEDS = 11
) ();
  logic [NUM_LEDS*24-1:0] strip_in;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   dout;

  modport master (output strip_in, output start, input busy, input done, input dout);
  modport slave  (input strip_in, input start, output busy, output done, output dout);
endinterface

// File: rtl/led_bit_encoder.sv
// Pulse-width encoder for one strip bit: high for T0H/T1H cycles, then low
// until T_BIT cycles have elapsed. A go on the final cycle chains the next bit.
module led_bit_encoder #(
  parameter int T_BIT = 63,
  parameter int T0H   = 20,
  parameter int T1H   = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  output logic dout_bit,
  output logic bit_done
);

  localparam int CNT_W = $clog2(T_BIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_lim;
  logic             active;
  logic             bit_reg;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign hi_lim   = bit_reg ? CNT_W'(T1H) : CNT_W'(T0H);
  assign bit_done = active && (cnt == CNT_W'(T_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      active   <= 1'b0;
      dout_bit <= 1'b0;
    end else if (go) begin
      cnt      <= '0;
      active   <= 1'b1;
      dout_bit <= 1'b1;
    end else if (bit_done) begin
      cnt      <= '0;
      active   <= 1'b0;
      dout_bit <= 1'b0;
    end else if (active) begin
      cnt      <= cnt_inc;
      dout_bit <= (cnt_inc < hi_lim);
    end
  end

  always_ff @(posedge clk) begin
    if (go) bit_reg <= bit_val;
  end

endmodule

// File: rtl/led_strip_tx.sv
// WS2812-style strip transmitter: snapshots a frame on start, streams every
// LED as pulse-width bits, then holds the line low for the latch gap.
// Optional build macro LED_TX_AUTO_REFRESH_EN: re-snapshot and resend forever.
module led_strip_tx
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS     = 11,
  parameter int T_BIT        = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 2500
) (
  input  logic            clk,
  input  logic            rst_n,
  led_strip_tx_if.slave   bus
);

  if (!(NUM_LEDS >= 1 && T0H >= 1 && T0H < T1H && T1H < T_BIT && RESET_CYCLES >= 1)) begin : g_bad_params
    $error("led_strip_tx: illegal timing parameters");
  end

  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W = $clog2(RESET_CYCLES) + 1;

  tx_state_t        state, state_nxt;
  color_t           snap [NUM_LEDS];
  logic [LED_W-1:0] led_idx, led_nxt;
  logic [4:0]       bit_idx, bit_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             load, adv, lat_clr, lat_inc;
  logic             go, go_bit;
  logic             enc_dout, bit_done;
  logic             last_bit;

  assign bit_nxt  = (bit_idx == 5'd23) ? 5'd0 : bit_idx + 5'd1;
  assign led_nxt  = (bit_idx == 5'd23) ? led_idx + LED_W'(1) : led_idx;
  assign last_bit = (led_idx == LED_W'(NUM_LEDS - 1)) && (bit_idx == 5'd23);

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    lat_clr   = 1'b0;
    lat_inc   = 1'b0;
    go        = 1'b0;
    go_bit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          go        = 1'b1;
          go_bit    = wire_bit(color_t'(bus.strip_in[23:0]), 5'd0);
          busy_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH, LOW: begin
        // The encoder's low phase may be a single cycle, so bit_done is
        // honoured in both states.
        if (bit_done) begin
          if (last_bit) begin
            lat_clr   = 1'b1;
            state_nxt = LATCH;
          end else begin
            adv       = 1'b1;
            go        = 1'b1;
            go_bit    = wire_bit(snap[led_nxt], bit_nxt);
            state_nxt = HIGH;
          end
        end else if (state == HIGH && !enc_dout) begin
          state_nxt = LOW;
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_W'(RESET_CYCLES - 1)) begin
          done_nxt  = 1'b1;
`ifdef LED_TX_AUTO_REFRESH_EN
          load      = 1'b1;
          go        = 1'b1;
          go_bit    = wire_bit(color_t'(bus.strip_in[23:0]), 5'd0);
          state_nxt = HIGH;
`else
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
`endif
        end else begin
          lat_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      led_idx <= '0;
      bit_idx <= '0;
      lat_cnt <= '0;
    end else begin
      state  <= state_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      if (load) begin
        led_idx <= '0;
        bit_idx <= '0;
      end else if (adv) begin
        led_idx <= led_nxt;
        bit_idx <= bit_nxt;
      end
      if (lat_clr)      lat_cnt <= '0;
      else if (lat_inc) lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  // Frame snapshot: isolates the frame in flight from strip_in changes.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM_LEDS; i++) snap[i] <= color_t'(bus.strip_in[24*i +: 24]);
    end
  end

  led_bit_encoder #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .bit_val  (go_bit),
    .dout_bit (enc_dout),
    .bit_done (bit_done)
  );

  assign bus.dout = enc_dout;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
Serial transmitter at the far end of the RGB controller array. It takes the per-LED 24-bit colour words produced by the controllers and drives a single-wire, WS2812-style LED strip line. On a start request it snapshots a whole frame and sends every LED's colour as pulse-width-coded bits. It then holds the line low for the latch/reset gap so the strip commits the new colours.

Parameters:
NUM_LEDS, 11, number of colour words per frame (LED 0 sent first)
T_BIT, 63, clock cycles per bit period (1.25 us at 50 MHz)
T0H, 20, high cycles for a 0 bit
T1H, 40, high cycles for a 1 bit
RESET_CYCLES, 2500, low cycles of the latch gap after the last bit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
strip_in  in  NUM_LEDS*24  frame; LED i = bits [24*i+23 : 24*i], packed {r[23:16], g[15:8], b[7:0]}
start  in  1  frame request, sampled only in IDLE
busy  out  1  high while a frame or its latch gap is in progress
done  out  1  one-cycle pulse when the latch gap completes
dout  out  1  serial strip data line

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, immediate, no clock needed): state=IDLE, dout=0, busy=0, done=0, all counters 0.
- All outputs are registered.
- Legal parameters: 1 <= T0H < T1H < T_BIT; RESET_CYCLES >= 1. Elaboration fails otherwise.
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - dout=0, busy=0.
  - When start=1 at a clock edge: latch all of strip_in into a snapshot register, set led index=0 and bit index=0, go to HIGH.
  - busy=1 and dout=1 from the next cycle.
- Wire byte order per LED is G, R, B, each MSB first, giving 24 bits per LED.
- HIGH: dout=1 for T0H cycles (bit 0) or T1H cycles (bit 1), then go to LOW.
- LOW: dout=0 for the remaining cycles of T_BIT (T_BIT - T0H or T_BIT - T1H). After that:
  - If more bits remain: advance the bit index (wraps 23 to 0 and increments the LED index), go to HIGH.
  - If the bit just sent was the last bit of LED NUM_LEDS-1: go to LATCH.
- LATCH: dout=0 for RESET_CYCLES cycles, then go to IDLE.
- done=1 for exactly the first IDLE cycle after LATCH.
- Total busy duration = NUM_LEDS*24*T_BIT + RESET_CYCLES cycles.
- Bit periods are back-to-back with no gap cycles.
- The snapshot is isolated: strip_in changes after the start cycle do not affect the frame in flight.
- start while busy=1 is ignored; it is not queued.
- start during the done cycle is accepted, because that cycle is IDLE.
- Reset mid-bit or mid-latch aborts the frame. No done is issued, and dout drops immediately.

Optional Feature:
LED_TX_AUTO_REFRESH_EN
- Defined: at the end of LATCH, the block re-snapshots strip_in and restarts at HIGH with no IDLE cycle. done still pulses for one cycle at each frame boundary, and busy stays 1 continuously. start only matters for the first frame.
- Undefined: single-shot behaviour as specified above.

Decomposition:
- Package led_strip_pkg:
  - color_t (24-bit packed r/g/b struct)
  - channel offset constants R_OFS=16, G_OFS=8, B_OFS=0
  - wire order constant (G, R, B)
  - FSM state enum
- Sub-module led_bit_encoder:
  - Inputs: bit value, go.
  - Owns the cycle counter and the high/low phase.
  - Outputs: dout_bit and bit_done.
  - The top level keeps the snapshot, the LED/bit indices and the LATCH counter.

Test Plan:
Bench parameters for all scenarios: NUM_LEDS=2, T_BIT=8, T0H=2, T1H=5, RESET_CYCLES=16.
1. Assert rst_n=0, no clock -> dout=0, busy=0, done=0. Release and idle 10 cycles -> outputs unchanged.
2. strip_in LED0=24'hFF0000, LED1=24'h000001; pulse start -> 48 bit periods with this high-time sequence:
   - LED0: 8×2 (G=00), 8×5 (R=FF), 8×2 (B=00)
   - LED1: 16×2, then 7×2 and 1×5 (last bit=1)
   - then 16 low cycles; busy high for exactly 400 cycles; done=1 on cycle 401 only.
3. Change strip_in to all 24'hFFFFFF mid-frame -> transmitted waveform identical to scenario 2.
4. Pulse start at cycle 50 of a frame -> no effect. Pulse start in the done cycle -> new frame; busy=1 on the next cycle.
5. Drop rst_n during a HIGH phase -> dout=0 immediately, busy=0, no done pulse. Next start sends a full, correct frame.
6. With LED_TX_AUTO_REFRESH_EN defined, single start, strip_in=24'h00FF00 -> continuous frames every 400 cycles, a done pulse at each boundary, busy never deasserts.
